// File: rtl/branch_update_scheduler.sv
// rtl/branch_update_scheduler.sv - in-order retire scheduler driving local branch predictor updates
module branch_update_scheduler #(
  parameter int HISTORY_LEN = 10,
  parameter int DEPTH       = 8,
  parameter int TAG_W       = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc_valid,
  input  logic [15:0]            alloc_pc,
  input  logic [HISTORY_LEN-1:0] alloc_history,
  input  logic                   alloc_prediction,
  output logic                   alloc_ready,
  output logic [TAG_W-1:0]       alloc_tag,
  input  logic                   resolve_valid,
  input  logic [TAG_W-1:0]       resolve_tag,
  input  logic                   resolve_outcome,
  output logic                   upd_write_enabled,
  output logic [15:0]            upd_pc,
  output logic [HISTORY_LEN-1:0] upd_history,
  output logic                   upd_outcome,
  output logic                   upd_rollback_enabled,
  output logic                   mispredict,
  output logic [15:0]            mispredict_pc,
  output logic                   resolve_error,
  output logic [TAG_W:0]         count
);
  typedef enum logic {RUN, FLUSH} state_e;
  localparam logic [TAG_W:0] PTR_ONE = 1;

  state_e                 state_q, state_d;
  logic [TAG_W:0]         head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]       valid_q, valid_d, resolved_q, resolved_d;
  logic [DEPTH-1:0]       outcome_q, pred_q;
  logic [15:0]            pc_q [DEPTH];
  logic [HISTORY_LEN-1:0] hist_q [DEPTH];

  logic                   upd_we_q, upd_outcome_q, rollback_q, mispredict_q, resolve_error_q;
  logic [15:0]            upd_pc_q, mispredict_pc_q;
  logic [HISTORY_LEN-1:0] upd_history_q;

  logic [TAG_W-1:0] head_idx, tail_idx;
  logic full, retire, retire_mispredict, alloc_fire, resolve_ok, resolve_bad;

  assign head_idx = head_q[TAG_W-1:0];
  assign tail_idx = tail_q[TAG_W-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[TAG_W] != tail_q[TAG_W]);

  assign retire_mispredict = valid_q[head_idx] && resolved_q[head_idx] &&
                             (outcome_q[head_idx] != pred_q[head_idx]);
  assign retire      = (state_q == RUN) && valid_q[head_idx] && resolved_q[head_idx];
  assign alloc_ready = reset && (state_q == RUN) && !full && !retire_mispredict;
  assign alloc_fire  = alloc_valid && alloc_ready;
  // A tag being allocated this cycle is still invalid, so it falls into the reject path.
  assign resolve_ok  = (state_q == RUN) && resolve_valid &&
                       valid_q[resolve_tag] && !resolved_q[resolve_tag];
  assign resolve_bad = (state_q == RUN) && resolve_valid && !resolve_ok;

  assign alloc_tag = tail_idx;
  assign count     = tail_q - head_q;

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    valid_d    = valid_q;
    resolved_d = resolved_q;
    if (state_q == FLUSH) begin
      valid_d    = '0;
      resolved_d = '0;
      tail_d     = head_q;
      state_d    = RUN;
    end else begin
      if (resolve_ok) resolved_d[resolve_tag] = 1'b1;
      if (retire) begin
        valid_d[head_idx]    = 1'b0;
        resolved_d[head_idx] = 1'b0;
        head_d               = head_q + PTR_ONE;
        if (retire_mispredict) state_d = FLUSH;
      end
      if (alloc_fire) begin
        valid_d[tail_idx]    = 1'b1;
        resolved_d[tail_idx] = 1'b0;
        tail_d               = tail_q + PTR_ONE;
      end
    end
  end

  // Payload storage is qualified by valid/resolved, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail_idx]   <= alloc_pc;
      hist_q[tail_idx] <= alloc_history;
      pred_q[tail_idx] <= alloc_prediction;
    end
    if (resolve_ok) outcome_q[resolve_tag] <= resolve_outcome;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= RUN;
      head_q          <= '0;
      tail_q          <= '0;
      valid_q         <= '0;
      resolved_q      <= '0;
      upd_we_q        <= 1'b0;
      upd_pc_q        <= '0;
      upd_history_q   <= '0;
      upd_outcome_q   <= 1'b0;
      rollback_q      <= 1'b0;
      mispredict_q    <= 1'b0;
      mispredict_pc_q <= '0;
      resolve_error_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      head_q          <= head_d;
      tail_q          <= tail_d;
      valid_q         <= valid_d;
      resolved_q      <= resolved_d;
      upd_we_q        <= retire;
      rollback_q      <= retire && retire_mispredict;
      mispredict_q    <= retire && retire_mispredict;
      resolve_error_q <= resolve_bad;
      if (retire) begin
        upd_pc_q      <= pc_q[head_idx];
        upd_history_q <= hist_q[head_idx];
        upd_outcome_q <= outcome_q[head_idx];
      end
      if (retire && retire_mispredict) mispredict_pc_q <= pc_q[head_idx];
    end
  end

  assign upd_write_enabled    = upd_we_q;
  assign upd_pc               = upd_pc_q;
  assign upd_history          = upd_history_q;
  assign upd_outcome          = upd_outcome_q;
  assign upd_rollback_enabled = rollback_q;
  assign mispredict           = mispredict_q;
  assign mispredict_pc        = mispredict_pc_q;
  assign resolve_error        = resolve_error_q;

endmodule

// File: tb/tb_branch_update_scheduler.sv
// tb/tb_branch_update_scheduler.sv - directed and randomized bench for branch_update_scheduler
module tb_branch_update_scheduler;
  localparam int HL    = 10;
  localparam int DEPTH = 8;
  localparam int TW    = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          alloc_valid = 1'b0;
  logic [15:0]   alloc_pc = '0;
  logic [HL-1:0] alloc_history = '0;
  logic          alloc_prediction = 1'b0;
  logic          alloc_ready;
  logic [TW-1:0] alloc_tag;
  logic          resolve_valid = 1'b0;
  logic [TW-1:0] resolve_tag = '0;
  logic          resolve_outcome = 1'b0;
  logic          upd_write_enabled, upd_outcome, upd_rollback_enabled, mispredict, resolve_error;
  logic [15:0]   upd_pc, mispredict_pc;
  logic [HL-1:0] upd_history;
  logic [TW:0]   count;

  always #5 clk = ~clk;

  branch_update_scheduler #(.HISTORY_LEN(HL), .DEPTH(DEPTH), .TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_history(alloc_history),
    .alloc_prediction(alloc_prediction), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag), .resolve_outcome(resolve_outcome),
    .upd_write_enabled(upd_write_enabled), .upd_pc(upd_pc), .upd_history(upd_history),
    .upd_outcome(upd_outcome), .upd_rollback_enabled(upd_rollback_enabled),
    .mispredict(mispredict), .mispredict_pc(mispredict_pc), .resolve_error(resolve_error),
    .count(count)
  );

  // Reference model: program-ordered queue of in-flight branches.
  typedef struct {
    logic [15:0]   pc;
    logic [HL-1:0] hist;
    logic          pred;
    logic          res;
    logic          out;
  } ent_t;
  ent_t q[$];
  int   head_ptr;
  bit   flush;

  logic          exp_we, exp_rb, exp_mis, exp_err, exp_out;
  logic [15:0]   exp_pc, exp_mpc;
  logic [HL-1:0] exp_hist;
  logic          pre_ready, obs_ready;
  logic [TW-1:0] pre_tag, obs_tag;
  logic [TW:0]   pre_count, obs_count;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic model_reset();
    q.delete();
    head_ptr = 0;
    flush = 0;
    {exp_we, exp_rb, exp_mis, exp_err, exp_out, exp_pc, exp_mpc, exp_hist} = '0;
  endtask

  task automatic drive_idle();
    alloc_valid = 1'b0;
    resolve_valid = 1'b0;
  endtask

  task automatic drive_alloc(input logic [15:0] pc, input logic [HL-1:0] hist, input logic pred);
    alloc_valid = 1'b1; alloc_pc = pc; alloc_history = hist; alloc_prediction = pred;
  endtask

  task automatic drive_resolve(input logic [TW-1:0] tag, input logic outc);
    resolve_valid = 1'b1; resolve_tag = tag; resolve_outcome = outc;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    ent_t e;
    int   idx;
    bit   do_ret, mis;
    #1;
    pre_ready = !flush && (q.size() < DEPTH) &&
                !(q.size() > 0 && q[0].res && (q[0].out != q[0].pred));
    pre_tag   = TW'((head_ptr + q.size()) % DEPTH);
    pre_count = (TW+1)'(q.size());
    obs_ready = alloc_ready;
    obs_tag   = alloc_tag;
    obs_count = count;
    @(posedge clk);
    do_ret  = !flush && q.size() > 0 && q[0].res;
    mis     = do_ret && (q[0].out != q[0].pred);
    exp_err = 1'b0;
    if (!flush && resolve_valid) begin
      idx = (int'(resolve_tag) - head_ptr + DEPTH) % DEPTH;
      if (idx < q.size() && !q[idx].res) begin
        q[idx].res = 1'b1;
        q[idx].out = resolve_outcome;
      end else exp_err = 1'b1;
    end
    exp_we = do_ret; exp_rb = mis; exp_mis = mis;
    if (do_ret) begin
      e = q.pop_front();
      head_ptr = (head_ptr + 1) % DEPTH;
      exp_pc = e.pc; exp_hist = e.hist; exp_out = e.out;
      if (mis) exp_mpc = e.pc;
    end
    if (flush) begin
      q.delete();
      flush = 0;
    end else if (alloc_valid && pre_ready) begin
      e.pc = alloc_pc; e.hist = alloc_history; e.pred = alloc_prediction; e.res = 1'b0; e.out = 1'b0;
      q.push_back(e);
    end
    if (mis) flush = 1;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    drive_idle();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({upd_write_enabled, upd_pc, upd_history, upd_outcome, upd_rollback_enabled, mispredict,
         mispredict_pc, resolve_error, alloc_ready, count} !== '0)
      $display("FAIL reset_outputs got we=%b pc=%h rdy=%b cnt=%0d want all zero",
               upd_write_enabled, upd_pc, alloc_ready, count);
    else n_pass++;
    reset = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if ({alloc_ready, alloc_tag, count} !== {1'b1, TW'(0), (TW+1)'(0)})
      $display("FAIL reset_release got rdy=%b tag=%0d cnt=%0d want 1/0/0", alloc_ready, alloc_tag, count);
    else n_pass++;
  endtask

  task automatic test_in_order_retire();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_idle(); drive_alloc(16'h10 + 16'(4 * i), HL'($urandom), 1'b1); cycle();
      n_checks++;
      if ({obs_ready, obs_tag} !== {1'b1, TW'(i)})
        $display("FAIL order_alloc_tag%0d got=%h want=%h", i, {obs_ready, obs_tag}, {1'b1, TW'(i)});
      else n_pass++;
    end
    drive_idle(); cycle();
    n_checks++;
    if ({obs_ready, obs_count} !== {1'b1, (TW+1)'(3)})
      $display("FAIL order_count got rdy=%b cnt=%0d want 1/3", obs_ready, obs_count);
    else n_pass++;
    drive_resolve(3'd2, 1'b1); cycle();
    drive_idle(); drive_resolve(3'd0, 1'b1); cycle();
    n_checks++;
    if (upd_write_enabled !== 1'b0) $display("FAIL order_no_early_retire got=%b want=0", upd_write_enabled);
    else n_pass++;
    drive_idle(); cycle();
    n_checks++;
    if ({upd_write_enabled, upd_pc, mispredict} !== {1'b1, 16'h10, 1'b0})
      $display("FAIL order_retire0 got we=%b pc=%h mis=%b want 1/0010/0", upd_write_enabled, upd_pc, mispredict);
    else n_pass++;
    drive_idle(); cycle();
    n_checks++;
    if (upd_write_enabled !== 1'b0) $display("FAIL order_wait_tag1 got=%b want=0", upd_write_enabled);
    else n_pass++;
    drive_resolve(3'd1, 1'b1); cycle();
    drive_idle(); cycle();
    n_checks++;
    if ({upd_write_enabled, upd_pc, upd_history} !== {1'b1, 16'h14, exp_hist})
      $display("FAIL order_retire1 got we=%b pc=%h want 1/0014", upd_write_enabled, upd_pc);
    else n_pass++;
    drive_idle(); cycle();
    n_checks++;
    if ({upd_write_enabled, upd_pc, upd_outcome, mispredict} !== {1'b1, 16'h18, 1'b1, 1'b0})
      $display("FAIL order_retire2 got we=%b pc=%h want 1/0018", upd_write_enabled, upd_pc);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive_alloc(16'h40 + 16'(4 * i), HL'($urandom), 1'b1); cycle();
    end
    drive_idle(); cycle();
    n_checks++;
    if ({obs_ready, obs_count} !== {1'b0, (TW+1)'(8)})
      $display("FAIL full_state got rdy=%b cnt=%0d want 0/8", obs_ready, obs_count);
    else n_pass++;
    drive_alloc(16'h80, '0, 1'b1); drive_resolve(3'd0, 1'b1); cycle();
    resolve_valid = 1'b0; cycle();
    n_checks++;
    if ({obs_ready, upd_write_enabled, upd_pc} !== {1'b0, 1'b1, 16'h40})
      $display("FAIL full_retire_no_alloc got rdy=%b we=%b pc=%h want 0/1/0040", obs_ready, upd_write_enabled, upd_pc);
    else n_pass++;
    cycle();
    n_checks++;
    if ({obs_ready, obs_tag, obs_count} !== {1'b1, TW'(0), (TW+1)'(7)})
      $display("FAIL full_wrap_tag got rdy=%b tag=%0d cnt=%0d want 1/0/7", obs_ready, obs_tag, obs_count);
    else n_pass++;
    drive_idle(); cycle();
    n_checks++;
    if (obs_count !== (TW+1)'(8)) $display("FAIL full_refill got=%0d want=8", obs_count);
    else n_pass++;
  endtask

  task automatic test_mispredict();
    bit any_we;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive_alloc(16'h100 + 16'(4 * i), HL'($urandom), 1'b1); cycle();
    end
    drive_idle(); drive_resolve(3'd1, 1'b1); cycle();
    drive_resolve(3'd0, 1'b0); cycle();
    drive_idle(); drive_alloc(16'h200, '0, 1'b1); cycle();
    n_checks++;
    if ({obs_ready, upd_write_enabled, upd_rollback_enabled, mispredict, mispredict_pc, upd_outcome} !==
        {1'b0, 1'b1, 1'b1, 1'b1, 16'h100, 1'b0})
      $display("FAIL misp_pulse got rdy=%b we=%b rb=%b mis=%b mpc=%h out=%b want 0/1/1/1/0100/0",
               obs_ready, upd_write_enabled, upd_rollback_enabled, mispredict, mispredict_pc, upd_outcome);
    else n_pass++;
    cycle();
    n_checks++;
    if ({obs_ready, upd_write_enabled, upd_rollback_enabled, mispredict} !== 4'b0)
      $display("FAIL misp_flush got rdy=%b we=%b rb=%b mis=%b want 0/0/0/0",
               obs_ready, upd_write_enabled, upd_rollback_enabled, mispredict);
    else n_pass++;
    drive_idle(); cycle();
    n_checks++;
    if ({obs_ready, obs_count, obs_tag} !== {1'b1, (TW+1)'(0), TW'(1)})
      $display("FAIL misp_after got rdy=%b cnt=%0d tag=%0d want 1/0/1", obs_ready, obs_count, obs_tag);
    else n_pass++;
    any_we = upd_write_enabled;
    repeat (4) begin cycle(); any_we |= upd_write_enabled; end
    n_checks++;
    if (any_we !== 1'b0) $display("FAIL misp_no_young_update got=%b want=0", any_we);
    else n_pass++;
  endtask

  task automatic test_resolve_error();
    apply_reset();
    drive_alloc(16'h300, HL'($urandom), 1'b1); cycle();
    drive_alloc(16'h304, HL'($urandom), 1'b1); cycle();
    drive_idle(); drive_resolve(3'd5, 1'b1); cycle();
    n_checks++;
    if (resolve_error !== 1'b1) $display("FAIL err_unalloc got=%b want=1", resolve_error);
    else n_pass++;
    drive_idle(); cycle();
    n_checks++;
    if (resolve_error !== 1'b0) $display("FAIL err_single_pulse got=%b want=0", resolve_error);
    else n_pass++;
    drive_resolve(3'd1, 1'b1); cycle();
    n_checks++;
    if (resolve_error !== 1'b0) $display("FAIL err_good_resolve got=%b want=0", resolve_error);
    else n_pass++;
    drive_resolve(3'd1, 1'b0); cycle();
    n_checks++;
    if (resolve_error !== 1'b1) $display("FAIL err_reresolve got=%b want=1", resolve_error);
    else n_pass++;
    drive_idle(); drive_alloc(16'h308, '0, 1'b1); drive_resolve(3'd2, 1'b1); cycle();
    n_checks++;
    if ({resolve_error, upd_write_enabled} !== 2'b10)
      $display("FAIL err_same_cycle_alloc got err=%b we=%b want 1/0", resolve_error, upd_write_enabled);
    else n_pass++;
    drive_idle(); drive_resolve(3'd0, 1'b1); cycle();
    n_checks++;
    if ({resolve_error, obs_count} !== {1'b0, (TW+1)'(3)})
      $display("FAIL err_contents got err=%b cnt=%0d want 0/3", resolve_error, obs_count);
    else n_pass++;
    drive_idle(); cycle();
    cycle();
    n_checks++;
    if ({upd_write_enabled, upd_pc, upd_outcome, mispredict} !== {1'b1, 16'h304, 1'b1, 1'b0})
      $display("FAIL err_outcome_kept got we=%b pc=%h out=%b mis=%b want 1/0304/1/0",
               upd_write_enabled, upd_pc, upd_outcome, mispredict);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bit any_we;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive_alloc(16'h400 + 16'(4 * i), HL'($urandom), 1'b1); cycle();
    end
    drive_idle();
    for (int i = 1; i < 6; i++) begin drive_resolve(TW'(i), 1'b1); cycle(); end
    drive_resolve(3'd0, 1'b1); cycle();
    drive_resolve(3'd7, 1'b1); cycle();
    drive_idle();
    n_checks++;
    if ({upd_write_enabled, resolve_error, upd_pc, count} !== {1'b1, 1'b1, 16'h400, (TW+1)'(5)})
      $display("FAIL areset_setup got we=%b err=%b pc=%h cnt=%0d want 1/1/0400/5",
               upd_write_enabled, resolve_error, upd_pc, count);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({upd_write_enabled, upd_pc, upd_history, upd_outcome, upd_rollback_enabled, mispredict,
         mispredict_pc, resolve_error, alloc_ready, count} !== '0)
      $display("FAIL areset_immediate got we=%b err=%b pc=%h rdy=%b cnt=%0d want all zero",
               upd_write_enabled, resolve_error, upd_pc, alloc_ready, count);
    else n_pass++;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    any_we = 1'b0;
    repeat (6) begin cycle(); any_we |= upd_write_enabled; end
    n_checks++;
    if ({any_we, obs_count} !== {1'b0, (TW+1)'(0)})
      $display("FAIL areset_discard got we_seen=%b cnt=%0d want 0/0", any_we, obs_count);
    else n_pass++;
  endtask

  task automatic test_random();
    int idx;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      alloc_valid = $urandom_range(1, 0) == 1;
      alloc_pc = 16'($urandom); alloc_history = HL'($urandom); alloc_prediction = 1'($urandom);
      resolve_valid = $urandom_range(1, 0) == 1;
      if (q.size() > 0 && $urandom_range(9, 0) < 8) begin
        idx = $urandom_range(q.size() - 1, 0);
        resolve_tag = TW'((head_ptr + idx) % DEPTH);
        resolve_outcome = ($urandom_range(7, 0) == 0) ? ~q[idx].pred : q[idx].pred;
      end else begin
        resolve_tag = TW'($urandom); resolve_outcome = 1'($urandom);
      end
      cycle();
      n_checks++;
      if ({obs_ready, obs_tag, obs_count} !== {pre_ready, pre_tag, pre_count})
        $display("FAIL rand_comb c%0d got rdy=%b tag=%0d cnt=%0d want %b/%0d/%0d",
                 c, obs_ready, obs_tag, obs_count, pre_ready, pre_tag, pre_count);
      else n_pass++;
      n_checks++;
      if ({upd_write_enabled, upd_rollback_enabled, mispredict, resolve_error} !== {exp_we, exp_rb, exp_mis, exp_err})
        $display("FAIL rand_strobes c%0d got we=%b rb=%b mis=%b err=%b want %b/%b/%b/%b", c,
                 upd_write_enabled, upd_rollback_enabled, mispredict, resolve_error, exp_we, exp_rb, exp_mis, exp_err);
      else n_pass++;
      if (exp_we) begin
        n_checks++;
        if ({upd_pc, upd_history, upd_outcome} !== {exp_pc, exp_hist, exp_out})
          $display("FAIL rand_update c%0d got pc=%h hist=%h out=%b want %h/%h/%b",
                   c, upd_pc, upd_history, upd_outcome, exp_pc, exp_hist, exp_out);
        else n_pass++;
      end
      if (exp_mis) begin
        n_checks++;
        if (mispredict_pc !== exp_mpc) $display("FAIL rand_mpc c%0d got=%h want=%h", c, mispredict_pc, exp_mpc);
        else n_pass++;
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_in_order_retire();
    test_full_wrap();
    test_mispredict();
    test_resolve_error();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/branch_update_scheduler.md
Name: branch_update_scheduler

Overview:
- Tracks every in-flight conditional branch from prediction to resolution.
- Accepts out-of-order resolutions and retires branches strictly in program order.
- Drives the write/update port of the local branch predictor (PHT/LHT) with one update per cycle.
- On a mispredict, pulses predictor rollback and flushes all younger in-flight entries.

Parameters:
HISTORY_LEN, 10, width of the local history snapshot stored per branch
DEPTH, 8, in-flight branch buffer entries; must be a power of 2, >= 2
TAG_W, 3, tag width; must equal log2(DEPTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
alloc_valid  input  1  fetch presents a predicted branch
alloc_pc  input  16  branch PC
alloc_history  input  HISTORY_LEN  local history used for the prediction
alloc_prediction  input  1  predicted direction (1 = taken)
alloc_ready  output  1  buffer can accept an allocation this cycle
alloc_tag  output  TAG_W  tag assigned to the allocation (equals tail index)
resolve_valid  input  1  execute reports a resolved branch
resolve_tag  input  TAG_W  tag of the resolved branch
resolve_outcome  input  1  actual direction
upd_write_enabled  output  1  predictor update strobe
upd_pc  output  16  PC of the retiring branch
upd_history  output  HISTORY_LEN  stored history of the retiring branch
upd_outcome  output  1  actual outcome of the retiring branch
upd_rollback_enabled  output  1  predictor speculative-history rollback
mispredict  output  1  one-cycle pulse on mispredicted retire
mispredict_pc  output  16  PC of the mispredicted branch
resolve_error  output  1  one-cycle pulse when a resolve is rejected
count  output  TAG_W+1  number of valid entries

Behaviour:

Reset (reset low, asynchronous):
- Pointers, count and all entry valid/resolved bits clear to 0; state goes to RUN.
- All registered outputs (upd_*, mispredict, mispredict_pc, resolve_error) go to 0.
- alloc_ready is forced 0 while reset is low.
- Reset mid-operation discards every entry; no update is emitted for discarded entries.

Storage and pointers:
- Circular buffer; each entry holds valid, resolved, outcome, prediction, pc and history.
- head/tail pointers are TAG_W+1 bits wide; the MSB is the wrap bit.
- full: indices equal and wrap bits differ. empty: indices and wrap bits all equal.
- count = tail - head, modulo 2^(TAG_W+1).

Allocation:
- alloc_ready = state==RUN && !full && !retire_mispredict (combinational).
- retire_mispredict = head valid && head resolved && head outcome != head prediction.
- When alloc_valid && alloc_ready at a clock edge: write the entry at tail (valid=1, resolved=0) and increment tail.
- alloc_tag = tail[TAG_W-1:0] at all times.
- No allocation is accepted when full, even if a retire occurs in the same cycle.

Resolution:
- When resolve_valid and the tag's entry is valid and not yet resolved: set resolved=1 and store the outcome.
- Otherwise, including a tag being allocated in the same cycle: ignore the resolve and pulse resolve_error on the next cycle.
- Resolves are ignored in FLUSH (no error pulse).

Retire (state RUN):
- Condition: head entry valid and resolved at the start of the cycle.
- At the edge: clear the entry, increment head, and register upd_write_enabled=1 plus upd_pc, upd_history and upd_outcome for exactly one cycle.
- A resolve written at edge N retires no earlier than edge N+1.
- Retire rate is at most one per cycle, always in order.
- If the retiring entry mispredicted:
  - upd_rollback_enabled, mispredict and mispredict_pc are driven in the same cycle as upd_write_enabled.
  - State goes to FLUSH.

FLUSH (exactly 1 cycle):
- Clear all valid bits and set tail = head.
- alloc_ready = 0.
- Return to RUN.

Simultaneous events:
- Allocation, resolution of a different tag, and retire may all occur in one cycle.
- Resolving the head in the same cycle it would retire has no effect on that retire; the head is not yet resolved at cycle start.

Width and wrap:
- Pointer arithmetic wraps modulo 2^(TAG_W+1); tags wrap modulo DEPTH.
- Unregistered outputs: alloc_ready, alloc_tag and count are combinational from state.

Test Plan:
1. Reset, then allocate 3 branches (pc 0x10, 0x14, 0x18; prediction 1) -> tags 0, 1, 2; count=3; alloc_ready=1.
2. Resolve tag 2 then tag 0, both with outcome 1 -> one cycle after resolving tag 0, upd_write_enabled pulses with upd_pc=0x10. No further retire until tag 1 resolves; then 0x14 and 0x18 retire on consecutive cycles. No mispredict.
3. Allocate 8 entries -> alloc_ready=0, count=8. Retire the head -> alloc_ready=1 the following cycle, and the next allocation gets tag 0 (wrap).
4. Allocate 4 entries (predicted 1), resolve the head with outcome 0 -> one-cycle pulse of upd_write_enabled, upd_rollback_enabled and mispredict with mispredict_pc equal to the head PC. Next cycle is FLUSH with alloc_ready=0. Then count=0 and no updates for the 3 younger entries.
5. Resolve an unallocated tag, and re-resolve an already-resolved tag -> resolve_error pulses once for each; buffer contents unchanged.
6. Drop reset low asynchronously between clock edges with 5 entries pending -> all outputs 0 immediately. After release: count=0 and no upd_write_enabled pulses.
